// File: rtl/pipeline_ctrl_pkg.sv
// Shared stall/flush encodings for the pipeline controller.
// Stall vector bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB.
package pipeline_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    RUN      = 1'b0,
    TO_FLUSH = 1'b1
  } ctrl_state_e;

  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout) + 1;
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter with selectable saturate or wrap on overflow.
// Ports: clk, rst (async active-low), inc, count[W-1:0].
module sat_counter #(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc) begin
      if (!(SAT && at_max)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: priority stall merge, exception redirect,
// MEM wait timeout with bus-error flush, and perf counters.
// Ports: clk, rst, stallreq_id/ex/mem, exc_valid, exc_new_pc ->
//   stall[5:0], flush, new_pc, bus_timeout, stall_cycles, flush_count.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          MEM_TIMEOUT   = 256,
  parameter logic [31:0] BUSERR_VECTOR = 32'h0000_0040
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stallreq_id,
  input  logic         stallreq_ex,
  input  logic         stallreq_mem,
  input  logic         exc_valid,
  input  logic [31:0]  exc_new_pc,
  output logic [5:0]   stall,
  output logic         flush,
  output logic [31:0]  new_pc,
  output logic         bus_timeout,
  output logic [31:0]  stall_cycles,
  output logic [15:0]  flush_count
);

  localparam int TW = timer_width(MEM_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  ctrl_state_e   state;
  logic [TW-1:0] timer;
  logic          mem_wait;
  logic          expire;

  // Timer only runs on MEM waits that no exception is about to flush.
  assign mem_wait = (state == RUN) && stallreq_mem && !exc_valid;
  assign expire   = mem_wait && (timer == TIMER_LAST);

  // Outputs are forced low while reset is held so the pipeline
  // registers see a clean idle pattern during reset.
  always_comb begin
    stall  = STALL_NONE;
    flush  = NOSTOP;
    new_pc = '0;
    if (!rst) begin
      stall  = STALL_NONE;
    end else if (exc_valid) begin
      flush  = STOP;
      new_pc = exc_new_pc;
    end else if (state == TO_FLUSH) begin
      flush  = STOP;
      new_pc = BUSERR_VECTOR;
    end else if (stallreq_mem) begin
      stall  = STALL_MEM;
    end else if (stallreq_ex) begin
      stall  = STALL_EX;
    end else if (stallreq_id) begin
      stall  = STALL_ID;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      timer       <= '0;
      bus_timeout <= 1'b0;
    end else begin
      state       <= RUN;
      timer       <= '0;
      bus_timeout <= 1'b0;
      if (expire) begin
        state       <= TO_FLUSH;
        bus_timeout <= 1'b1;
      end else if (mem_wait) begin
        timer <= timer + 1'b1;
      end
    end
  end

  sat_counter #(
    .W   (32),
    .SAT (1'b0)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (|stall),
    .count (stall_cycles)
  );

  sat_counter #(
    .W   (16),
    .SAT (1'b1)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short MEM timeout.
// Also exercises a narrow wrapping sat_counter.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        exc_valid;
  logic [31:0] exc_new_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  logic        w_inc;
  logic [3:0]  w_count;

  int checks;
  int failures;

  pipeline_ctrl #(
    .MEM_TIMEOUT   (4),
    .BUSERR_VECTOR (32'h0000_0040)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .exc_valid    (exc_valid),
    .exc_new_pc   (exc_new_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .bus_timeout  (bus_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  sat_counter #(
    .W   (4),
    .SAT (1'b0)
  ) u_wrap (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc),
    .count (w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b1;
    exc_valid    = 1'b0;
    exc_new_pc   = '0;
    w_inc        = 1'b0;
    repeat (2) tick();

    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_newpc", new_pc, 32'h0);
    check("rst_busto", 32'(bus_timeout), 32'h0);
    check("rst_sc", stall_cycles, 32'h0);
    check("rst_fc", 32'(flush_count), 32'h0);

    rst = 1'b1;
    settle();
    check("rel_stall", 32'(stall), 32'h1f);
    tick();
    check("mid_sc", stall_cycles, 32'd1);
    rst = 1'b0;
    settle();
    check("mid_rst_stall", 32'(stall), 32'h0);
    check("mid_rst_sc", stall_cycles, 32'h0);
    rst = 1'b1;
    settle();
    check("rel2_stall", 32'(stall), 32'h1f);

    stallreq_id = 1'b1;
    stallreq_ex = 1'b1;
    settle();
    check("pri_mem", 32'(stall), 32'h1f);
    tick();
    stallreq_mem = 1'b0;
    settle();
    check("pri_ex", 32'(stall), 32'h0f);
    tick();
    stallreq_ex = 1'b0;
    settle();
    check("pri_id", 32'(stall), 32'h07);
    tick();
    stallreq_id = 1'b0;
    settle();
    check("pri_none", 32'(stall), 32'h0);
    check("pri_sc", stall_cycles, 32'd3);

    exc_valid    = 1'b1;
    exc_new_pc   = 32'h0000_0180;
    stallreq_mem = 1'b1;
    settle();
    check("exc_flush", 32'(flush), 32'h1);
    check("exc_newpc", new_pc, 32'h180);
    check("exc_stall", 32'(stall), 32'h0);
    tick();
    check("exc_fc", 32'(flush_count), 32'd1);
    check("exc_sc", stall_cycles, 32'd3);
    exc_valid    = 1'b0;
    stallreq_mem = 1'b0;
    tick();

    stallreq_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("to_stall%0d", i), 32'(stall), 32'h1f);
      check($sformatf("to_noflush%0d", i), 32'(flush), 32'h0);
      tick();
    end
    check("to_flush", 32'(flush), 32'h1);
    check("to_newpc", new_pc, 32'h40);
    check("to_busto", 32'(bus_timeout), 32'h1);
    check("to_stall0", 32'(stall), 32'h0);
    tick();
    check("to_resume", 32'(stall), 32'h1f);
    check("to_pulse_end", 32'(bus_timeout), 32'h0);
    check("to_fc", 32'(flush_count), 32'd2);
    check("to_sc", stall_cycles, 32'd7);
    stallreq_mem = 1'b0;
    tick();

    stallreq_mem = 1'b1;
    repeat (3) tick();
    exc_valid  = 1'b1;
    exc_new_pc = 32'h0000_0200;
    settle();
    check("race_newpc", new_pc, 32'h200);
    check("race_flush", 32'(flush), 32'h1);
    tick();
    exc_valid = 1'b0;
    settle();
    check("race_busto", 32'(bus_timeout), 32'h0);
    check("race_noflush", 32'(flush), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("race_run%0d", i), 32'(flush), 32'h0);
    end
    tick();
    check("race_to_busto", 32'(bus_timeout), 32'h1);
    check("race_to_newpc", new_pc, 32'h40);
    exc_valid  = 1'b1;
    exc_new_pc = 32'h0000_0300;
    settle();
    check("tf_exc_newpc", new_pc, 32'h300);
    check("tf_exc_busto", 32'(bus_timeout), 32'h1);
    tick();
    exc_valid    = 1'b0;
    stallreq_mem = 1'b0;
    settle();
    check("tf_exc_fc", 32'(flush_count), 32'd4);
    check("tf_exc_sc", stall_cycles, 32'd14);

    stallreq_mem = 1'b1;
    repeat (3) tick();
    stallreq_mem = 1'b0;
    tick();
    check("drop_noflush", 32'(flush), 32'h0);
    check("drop_busto", 32'(bus_timeout), 32'h0);
    stallreq_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("drop_run%0d", i), 32'(flush), 32'h0);
    end
    tick();
    check("drop_to_flush", 32'(flush), 32'h1);
    stallreq_mem = 1'b0;
    tick();
    check("drop_fc", 32'(flush_count), 32'd5);
    check("drop_sc", stall_cycles, 32'd21);

    exc_valid  = 1'b1;
    exc_new_pc = 32'h0000_0180;
    repeat (65536) tick();
    check("sat_fc", 32'(flush_count), 32'h0000_ffff);
    tick();
    check("sat_fc_hold", 32'(flush_count), 32'h0000_ffff);
    check("sat_sc", stall_cycles, 32'd21);
    exc_valid = 1'b0;

    w_inc = 1'b1;
    repeat (15) tick();
    check("wrap_max", 32'(w_count), 32'hf);
    tick();
    check("wrap_zero", 32'(w_count), 32'h0);
    w_inc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
